// File: rtl/mux16_rr_scheduler_pkg.sv
// Shared types and constants for the 16-way round-robin selector scheduler.
package mux16_rr_scheduler_pkg;

    localparam int NUM_REQ = 16;
    localparam int SEL_W   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        HOLD    = 2'b01,
        RELEASE = 2'b10
    } state_t;

    // The shared selector routes data line 15-s for select value s,
    // so the select that reaches requester idx is its bitwise inverse.
    function automatic logic [SEL_W-1:0] sel_for(input logic [SEL_W-1:0] idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/mux16_rr_scheduler_pick.sv
// Combinational round-robin pick: first set request strictly after ptr,
// searching upward and wrapping 15 -> 0.
module rr_pick16
    import mux16_rr_scheduler_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [NUM_REQ-1:0] rot;
    logic [SEL_W-1:0]   off;

    // Rotate so that bit 0 of rot is the requester just after ptr.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            rot[i] = req[SEL_W'(i + int'(ptr) + 1)];
        end
    end

    // Lowest set bit of the rotated vector is the winner's distance past ptr+1.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves it unassigned would infer a latch.
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
    end

    assign found = |req;
    // 4-bit addition wraps naturally, undoing the rotation mod 16.
    assign idx   = ptr + SEL_W'(1) + off;

endmodule

// File: rtl/mux16_rr_scheduler.sv
// Round-robin arbiter sharing one 16:1 selector between 16 requesters.
// Each grant is held until done, withdrawal, disable or MAX_HOLD cycles,
// followed by one dead RELEASE cycle before the next grant.
module mux16_rr_scheduler
    import mux16_rr_scheduler_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [NUM_REQ-1:0]   req,
    input  logic                 done,
    output logic [NUM_REQ-1:0]   grant,
    output logic [SEL_W-1:0]     sel,
    output logic                 busy,
    output logic                 timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] grant_d;
    logic [SEL_W-1:0]   sel_d;
    logic               busy_d;
    logic               timeout_d;

    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic               early_rel;
    logic               hold_last;

    rr_pick16 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Voluntary/forced release reasons outrank the hold-limit timeout.
    assign early_rel = done | ~req[ptr_q] | ~enable;
    assign hold_last = (cnt_q == HOLD_LAST);

    // Next-state and next-output logic for the IDLE/HOLD/RELEASE sequencer.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        grant_d   = grant;
        sel_d     = sel;
        busy_d    = busy;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                if (enable && pick_found) begin
                    state_d           = HOLD;
                    grant_d[pick_idx] = 1'b1;
                    sel_d             = sel_for(pick_idx);
                    ptr_d             = pick_idx;
                    cnt_d             = '0;
                    busy_d            = 1'b1;
                end
            end

            HOLD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (early_rel || hold_last) begin
                    state_d   = RELEASE;
                    grant_d   = '0;
                    timeout_d = hold_last && !early_rel;
                end
            end

            RELEASE: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State, pointer, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= SEL_W'(NUM_REQ - 1);
            cnt_q   <= '0;
            grant   <= '0;
            sel     <= sel_for('0);
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples the pre-edge values, independent of order.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant   <= grant_d;
            sel     <= sel_d;
            busy    <= busy_d;
            timeout <= timeout_d;
        end
    end

endmodule

// File: doc/mux16_rr_scheduler.md
Name: mux16_rr_scheduler

Overview:
- Round-robin arbiter and sequencer that shares the team's 16:1 gate-level selector between 16 requesters.
- Grants one requester at a time and drives the selector's 4-bit select so that the granted requester's line reaches the shared output.
- Holds each grant until release or timeout, then inserts one dead cycle (break-before-make) before the next grant.
- Sits between the requester bank and the selector's select input.

Parameters:
- MAX_HOLD, 16: maximum HOLD cycles per grant before forced release (legal range 2..256).
- CNT_W, 8: hold-counter width; must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  scheduler enable; low blocks new grants and forces release of an active grant.
- req  input  16  request vector; bit i is requester i.
- done  input  1  granted requester signals it has finished (sampled only in HOLD).
- grant  output  16  one-hot grant, registered; all zero outside HOLD.
- sel  output  4  selector select, registered. Selector mapping: sel=s routes data line 15-s, so sel = ~idx (bitwise NOT of granted index).
- busy  output  1  high in HOLD and RELEASE.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, grant=0, busy=0, timeout=0, hold_cnt=0.
  - ptr=4'd15, so requester 0 has first priority.
  - sel=4'hF (selector parked on requester 0).
- States are IDLE, HOLD and RELEASE; all outputs are registered.
- IDLE:
  - If enable=1 and |req=1, pick the winner: the first set req bit searching from ptr+1 upward, wrapping 15->0 (mod 16).
  - Next edge: grant=onehot(winner), sel=~winner, ptr=winner, hold_cnt=0, state=HOLD.
  - Latency is one clock from req sampled high to grant high.
  - Otherwise stay in IDLE; sel keeps its last value.
- HOLD:
  - hold_cnt increments every cycle.
  - Exit to RELEASE on the first edge where any of these holds:
    - (a) done=1
    - (b) req[ptr]=0 (requester withdrew)
    - (c) enable=0
    - (d) hold_cnt==MAX_HOLD-1
  - If (d) holds and none of (a)-(c) holds, pulse timeout=1 for the RELEASE cycle.
  - Priority when several hold on the same edge: (a)/(b)/(c) take precedence over (d); no timeout pulse in that case.
  - Requests from other requesters are ignored; there is no preemption.
- RELEASE:
  - Exactly one cycle with grant=0, busy=1; sel unchanged.
  - Next state is IDLE unconditionally; re-arbitration happens in IDLE, so the minimum grant-to-grant spacing is 3 cycles.
- Fairness:
  - ptr updates only on grant.
  - A requester holding req high continuously is granted within 15 other grants.
- Boundaries:
  - req=16'hFFFF: grants rotate 0,1,...,15,0.
  - Wrap at ptr=15: search starts at 0.
  - A single requester re-requesting is granted again (search wraps back to itself).
  - req changing during RELEASE has no effect until IDLE.
  - done while in IDLE or RELEASE is ignored.
  - rst_n asserted mid-HOLD: grant drops immediately (asynchronously); no timeout pulse.
- Invariants:
  - grant is one-hot or zero.
  - When grant!=0, sel==~index(grant).

Decomposition:
- Shared package holds:
  - State encoding: IDLE=2'b00, HOLD=2'b01, RELEASE=2'b10.
  - NUM_REQ=16, SEL_W=4.
- One natural sub-module, rr_pick16:
  - Combinational.
  - Inputs: req[15:0], ptr[3:0].
  - Outputs: found, idx[3:0].
  - Implementation: rotate req right by ptr+1, priority-encode, add back mod 16.
- Top level holds the FSM, hold counter and output registers.

Test Plan:
- Reset then req=16'h0001 → grant=16'h0001 one clock later, sel=4'hF, busy=1; done=1 → RELEASE (grant=0), then IDLE.
- req=16'hFFFF held, done pulsed each grant → grant order 0,1,2,...,15,0 with sel=F,E,...,0,F; 3-cycle spacing between grants.
- Grant requester 15, then req=16'h8001 → next grant is requester 0 (wrap), sel=4'hF.
- MAX_HOLD=16, req[3] held, done never asserted → grant=16'h0008 for exactly 16 cycles, timeout pulses once in RELEASE; a same-cycle done on the last cycle suppresses the pulse.
- enable dropped mid-HOLD → RELEASE next edge, no timeout; while enable=0 with req=16'h00F0, no grant; enable=1 → grant requester 4.
- rst_n low for 1 cycle mid-HOLD → grant=0, sel=4'hF, ptr=15 immediately; after release with req=16'h0006 → requester 1 granted.
